im_loader: RTL and testbench

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_loader.sv | 139 +++++++++++++
 tb/tb_im_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/im_loader.sv
// Serial instruction-memory loader: parses a count header, assembles big-endian
// 32-bit words, writes them one per strobe and verifies a trailing XOR checksum.
module im_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [7:0]          chk_q, chk_d;
    logic [23:0]         word_q, word_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                accept;
    logic [16:0]         n_words;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_hi_q  <= '0;
            last_q    <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            chk_q     <= '0;
            word_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_hi_q  <= cnt_hi_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            chk_q     <= chk_d;
            word_q    <= word_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy       = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                        (state_q == DATA)   || (state_q == CHK);
    assign byte_ready = busy;
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign accept     = byte_valid && byte_ready;
    assign n_words    = {1'b0, cnt_hi_q, byte_in};

    always_comb begin
        state_d   = state_q;
        cnt_hi_d  = cnt_hi_q;
        last_d    = last_q;
        idx_d     = idx_q;
        bcnt_d    = bcnt_q;
        chk_d     = chk_q;
        word_d    = word_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (load_start) begin
                    state_d = HDR_HI;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    chk_d   = '0;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    cnt_hi_d = byte_in;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    if ((n_words >= 17'd1) && (n_words <= MAX_N)) begin
                        // Keep N-1 so the last word is found by equality on the index.
                        last_d  = ADDR_W'(n_words - 17'd1);
                        state_d = DATA;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    chk_d  = chk_q ^ byte_in;
                    bcnt_d = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: word_d[23:16] = byte_in;
                        2'd1: word_d[15:8]  = byte_in;
                        2'd2: word_d[7:0]   = byte_in;
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q;
                            wr_data_d = {word_q, byte_in};
                            if (idx_q == last_q) state_d = CHK;
                            else                 idx_d   = idx_q + 1'b1;
                        end
                    endcase
                end
            end
            CHK: begin
                if (accept) state_d = (byte_in == chk_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: stimulus pushes expected writes to a scoreboard,
// a negedge monitor pops and compares them, including the cycle they land in.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready, wr_en, busy, done, err;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] words_q[$];

    im_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_wr", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", wr_data, e.d);
                check("wr_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    task automatic idle_gap(input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        idle_gap(gap);
    endtask

    // The write for a word must appear in the cycle right after its 4th byte is taken.
    task automatic send_last(input logic [7:0] b, input int gap, input int k, input logic [31:0] w);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        sb.push_back('{a: 10'(k), d: w, c: cyc + 1});
        #1;
        byte_valid = 1'b0;
        idle_gap(gap);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic run_load(input int gap, input bit bad, input bit poke, input bit start);
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        logic [7:0]  b;
        cs = 8'h00;
        n  = 16'(words_q.size());
        if (start) pulse_start();
        send(n[15:8], gap);
        send(n[7:0], gap);
        for (int k = 0; k < words_q.size(); k++) begin
            w = words_q[k];
            for (int j = 0; j < 4; j++) begin
                b  = w[31-8*j -: 8];
                cs = cs ^ b;
                if (j == 3) begin
                    send_last(b, gap, k, w);
                end else begin
                    if (poke && k == 0 && j == 1) load_start = 1'b1;
                    send(b, gap);
                    load_start = 1'b0;
                end
            end
        end
        send(bad ? (cs ^ 8'h88) : cs, gap);
    endtask

    task automatic load_two();
        words_q.delete();
        words_q.push_back(32'h12345678);
        words_q.push_back(32'h9ABCDEF0);
    endtask

    initial begin
        #1;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        idle_gap(2);
        rst_n = 1'b1;
        idle_gap(3);
        check("idle_hold_busy", 32'(busy), 32'd0);

        // Good 2-word load; the XOR of these eight bytes is 0x00.
        load_two();
        run_load(0, 1'b0, 1'b0, 1'b1);
        check("good_done", 32'(done), 32'd1);
        check("good_err", 32'(err), 32'd0);
        check("good_busy", 32'(busy), 32'd0);
        check("good_ready", 32'(byte_ready), 32'd0);
        idle_gap(2);
        check("hold_wr_addr", 32'(wr_addr), 32'd1);
        check("hold_wr_data", wr_data, 32'h9ABCDEF0);

        // Wrong checksum byte: both writes still happen, load fails.
        run_load(0, 1'b1, 1'b0, 1'b1);
        idle_gap(1);
        check("badchk_err", 32'(err), 32'd1);
        check("badchk_done", 32'(done), 32'd0);

        // Illegal word counts.
        words_q.delete();
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_err_clr", 32'(err), 32'd0);
        send(8'h00, 0);
        send(8'h00, 0);
        check("n0_err", 32'(err), 32'd1);
        check("n0_ready", 32'(byte_ready), 32'd0);
        pulse_start();
        send(8'h04, 0);
        send(8'h01, 0);
        check("n1025_err", 32'(err), 32'd1);
        check("n1025_ready", 32'(byte_ready), 32'd0);
        check("n1025_busy", 32'(busy), 32'd0);

        // Toggling byte_valid, with a load_start poked mid-load that must be ignored.
        load_two();
        run_load(1, 1'b0, 1'b1, 1'b1);
        check("toggle_done", 32'(done), 32'd1);

        // load_start with a byte in DONE: the byte must not be taken as count_hi.
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hFF;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        check("restart_busy", 32'(busy), 32'd1);
        words_q.delete();
        words_q.push_back(32'hCAFEF00D);
        run_load(0, 1'b0, 1'b0, 1'b0);
        check("restart_done", 32'(done), 32'd1);

        // Maximum-length load with random data.
        words_q.delete();
        for (int i = 0; i < 1024; i++) words_q.push_back($urandom);
        run_load(0, 1'b0, 1'b0, 1'b1);
        check("max_done", 32'(done), 32'd1);
        check("max_err", 32'(err), 32'd0);
        check("max_sb_drained", 32'(sb.size()), 32'd0);

        // Reset after six data bytes, then a clean restart.
        load_two();
        pulse_start();
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        send(8'h56, 0);
        send_last(8'h78, 0, 0, 32'h12345678);
        send(8'h9A, 0);
        send(8'hBC, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_wr_data", wr_data, 32'd0);
        check("mid_rst_done_err", 32'({done, err}), 32'd0);
        idle_gap(2);
        rst_n = 1'b1;
        idle_gap(3);
        check("post_rst_idle", 32'(busy), 32'd0);
        run_load(0, 1'b0, 1'b0, 1'b1);
        check("rerun_done", 32'(done), 32'd1);
        idle_gap(3);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
